// File: rtl/fifo_wr_arbiter.sv
// rtl/fifo_wr_arbiter.sv - round-robin burst arbiter sharing one FIFO write port
//
// Purpose: grants one of NUM_REQ producers the FIFO write port for a burst of
// up to MAX_BURST words, then releases for one IDLE cycle and re-arbitrates
// round-robin starting after the last owner.
// Optional feature macro: FIFO_ARB_PRIO_EN (producer 0 wins every arbitration
// it takes part in; bursts are never pre-empted).
//
// Ports:
//   clk_i           system clock, rising edge
//   rst_i           synchronous active-high reset
//   req_i           per-producer valid
//   req_data_i      producer i word in [i*DATA_W +: DATA_W]
//   ack_o           one-hot, producer word written this cycle
//   fifo_full_i     FIFO full flag
//   fifo_wr_en_o    FIFO write enable
//   fifo_data_in_o  FIFO write data (0 in IDLE)
//   busy_o          high while in BURST
//   owner_o         current or last owner index
module fifo_wr_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NUM_REQ-1:0]        req_i,
    input  logic [NUM_REQ*DATA_W-1:0] req_data_i,
    output logic [NUM_REQ-1:0]        ack_o,
    input  logic                      fifo_full_i,
    output logic                      fifo_wr_en_o,
    output logic [DATA_W-1:0]         fifo_data_in_o,
    output logic                      busy_o,
    output logic [2:0]                owner_o
);

    typedef enum logic {
        S_IDLE  = 1'b0,
        S_BURST = 1'b1
    } state_t;

    localparam logic [2:0] LAST_IDX  = 3'(NUM_REQ - 1);
    localparam logic [3:0] LAST_BEAT = 4'(MAX_BURST - 1);

    state_t      state_q, state_d;
    logic [2:0]  owner_q, owner_d;
    logic [2:0]  rr_ptr_q, rr_ptr_d;
    logic [3:0]  burst_cnt_q, burst_cnt_d;

    // Requests zero-padded to 8 bits so 3-bit indices select directly.
    logic [7:0]        req_pad;
    logic              owner_req;
    logic [DATA_W-1:0] owner_data;
    logic              rr_found;
    logic [2:0]        rr_winner;
    logic [2:0]        winner;
    logic              accept;
    logic              release_now;

    assign req_pad   = 8'(req_i);
    assign owner_req = req_pad[owner_q];

    always_comb begin
        owner_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == 3'(i)) begin
                owner_data = req_data_i[i*DATA_W +: DATA_W];
            end
        end
    end

    // Ascending search from rr_ptr, wrapping by compare against NUM_REQ-1.
    always_comb begin
        logic [2:0] idx;
        rr_found  = 1'b0;
        rr_winner = rr_ptr_q;
        idx       = rr_ptr_q;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!rr_found && req_pad[idx]) begin
                rr_found  = 1'b1;
                rr_winner = idx;
            end
            idx = (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
        end
    end

`ifdef FIFO_ARB_PRIO_EN
    assign winner = req_pad[0] ? 3'd0 : rr_winner;
`else
    assign winner = rr_winner;
`endif

    // Reset gates the write path combinationally so nothing leaks during rst.
    assign accept = (state_q == S_BURST) && owner_req && !fifo_full_i && !rst_i;

    always_comb begin
        ack_o = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept && (owner_q == 3'(i))) begin
                ack_o[i] = 1'b1;
            end
        end
    end

    assign fifo_wr_en_o   = accept;
    assign fifo_data_in_o = (state_q == S_BURST) ? owner_data : '0;
    assign busy_o         = (state_q == S_BURST);
    assign owner_o        = owner_q;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        burst_cnt_d = burst_cnt_q;
        release_now = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (|req_i) begin
                    owner_d     = winner;
                    burst_cnt_d = 4'd0;
                    state_d     = S_BURST;
                end
            end
            S_BURST: begin
                // A dropped request ends the burst even while the FIFO is full.
                if (!owner_req) begin
                    release_now = 1'b1;
                end else if (!fifo_full_i) begin
                    burst_cnt_d = burst_cnt_q + 4'd1;
                    if (burst_cnt_q == LAST_BEAT) begin
                        release_now = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (release_now) begin
            state_d  = S_IDLE;
            rr_ptr_d = (owner_q == LAST_IDX) ? 3'd0 : owner_q + 3'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= S_IDLE;
            owner_q     <= 3'd0;
            rr_ptr_q    <= 3'd0;
            burst_cnt_q <= 4'd0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            burst_cnt_q <= burst_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb/tb_fifo_wr_arbiter.sv - scoreboard bench for fifo_wr_arbiter
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;

    logic             clk = 1'b0;
    logic             rst_i;
    logic [NR-1:0]    req_i;
    logic [NR*DW-1:0] req_data_i;
    logic [NR-1:0]    ack_o;
    logic             fifo_full_i;
    logic             fifo_wr_en_o;
    logic [DW-1:0]    fifo_data_in_o;
    logic             busy_o;
    logic [2:0]       owner_o;

    fifo_wr_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .MAX_BURST(4)) dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .req_i          (req_i),
        .req_data_i     (req_data_i),
        .ack_o          (ack_o),
        .fifo_full_i    (fifo_full_i),
        .fifo_wr_en_o   (fifo_wr_en_o),
        .fifo_data_in_o (fifo_data_in_o),
        .busy_o         (busy_o),
        .owner_o        (owner_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         cyc;
        int         id;
        logic [7:0] data;
    } exp_t;

    exp_t       sbq[$];
    int         cyc = 0;
    int         checks = 0;
    int         failures = 0;
    int         t0;
    int         rem[NR];
    logic [7:0] nxt[NR];

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every write (or stray ack) must match the head of the scoreboard.
    exp_t          e;
    logic [NR-1:0] ea;
    always @(negedge clk) begin
        if (fifo_wr_en_o || (ack_o != '0)) begin
            checks++;
            if (sbq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write cyc=%0d ack=%b data=%h required no write",
                         cyc, ack_o, fifo_data_in_o);
            end else begin
                e = sbq.pop_front();
                ea = '0;
                ea[e.id] = 1'b1;
                if (!fifo_wr_en_o || ack_o != ea || fifo_data_in_o != e.data || cyc != e.cyc) begin
                    failures++;
                    $display("FAIL write cyc=%0d wr_en=%b ack=%b data=%h required cyc=%0d ack=%b data=%h",
                             cyc, fifo_wr_en_o, ack_o, fifo_data_in_o, e.cyc, ea, e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic drive();
        for (int i = 0; i < NR; i++) begin
            req_i[i]             = (rem[i] != 0);
            req_data_i[i*DW +: DW] = nxt[i];
        end
    endtask

    task automatic load(input int i, input int n);
        rem[i] = n;
        nxt[i] = 8'(i * 16);
    endtask

    task automatic expw(input int rel, input int id, input int d);
        exp_t x;
        x.cyc  = t0 + rel;
        x.id   = id;
        x.data = 8'(d);
        sbq.push_back(x);
    endtask

    // One clock: capture acks mid-cycle, then advance producers after the edge.
    task automatic tick();
        logic [NR-1:0] s;
        @(negedge clk);
        s = ack_o;
        @(posedge clk);
        #1;
        for (int i = 0; i < NR; i++) begin
            if (s[i] && rem[i] != 0) begin
                rem[i]--;
                nxt[i]++;
            end
        end
        drive();
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        for (int i = 0; i < NR; i++) load(i, 0);
        drive();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic start();
        drive();
        t0 = cyc;
    endtask

    initial begin
        rst_i       = 1'b1;
        fifo_full_i = 1'b0;
        for (int i = 0; i < NR; i++) load(i, 1);
        drive();
        tick();
        tick();
        #2;
        chk("rst_ack", 32'(ack_o), 32'd0);
        chk("rst_wr_en", 32'(fifo_wr_en_o), 32'd0);
        tick();
        rst_i = 1'b0;
        for (int i = 0; i < NR; i++) load(i, 0);
        drive();
        #1;
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_owner", 32'(owner_o), 32'd0);
        chk("rst_data", 32'(fifo_data_in_o), 32'd0);

        // Producer 1 alone, 6 words: 4-word burst, bubble, 2 more.
        load(1, 6);
        start();
        for (int k = 0; k < 4; k++) expw(1 + k, 1, 8'h10 + k);
        expw(6, 1, 8'h14);
        expw(7, 1, 8'h15);
        tick();
        tick();
        chk("s1_owner", 32'(owner_o), 32'd1);
        chk("s1_busy", 32'(busy_o), 32'd1);
        repeat (10) tick();

        // All four requesting from reset: order 0,1,2,3 (then 0 again).
        do_reset();
`ifdef FIFO_ARB_PRIO_EN
        load(0, 4);
`else
        load(0, 8);
`endif
        load(1, 4);
        load(2, 4);
        load(3, 4);
        start();
        for (int g = 0; g < 4; g++)
            for (int k = 0; k < 4; k++) expw(1 + 5 * g + k, g, 16 * g + k);
`ifndef FIFO_ARB_PRIO_EN
        for (int k = 0; k < 4; k++) expw(21 + k, 0, 4 + k);
`endif
        repeat (30) tick();
        chk("s2_busy_end", 32'(busy_o), 32'd0);

        // FIFO full for 3 cycles after producer 2's second word.
        do_reset();
        load(2, 4);
        start();
        expw(1, 2, 8'h20);
        expw(2, 2, 8'h21);
        expw(6, 2, 8'h22);
        expw(7, 2, 8'h23);
        tick();
        tick();
        tick();
        fifo_full_i = 1'b1;
        tick();
        #1;
        chk("s3_full_wr_en", 32'(fifo_wr_en_o), 32'd0);
        chk("s3_full_owner", 32'(owner_o), 32'd2);
        chk("s3_full_busy", 32'(busy_o), 32'd1);
        tick();
        tick();
        fifo_full_i = 1'b0;
        repeat (6) tick();

        // rr_ptr now 3: producer 3 drops after 2 words, then producer 0.
        load(3, 2);
        load(0, 2);
        start();
`ifdef FIFO_ARB_PRIO_EN
        expw(1, 0, 8'h00);
        expw(2, 0, 8'h01);
        expw(5, 3, 8'h30);
        expw(6, 3, 8'h31);
`else
        expw(1, 3, 8'h30);
        expw(2, 3, 8'h31);
        expw(5, 0, 8'h00);
        expw(6, 0, 8'h01);
`endif
        repeat (10) tick();

        // Reset pulse mid-burst (owner 1, 2 words done).
        do_reset();
        load(1, 4);
        start();
        expw(1, 1, 8'h10);
        expw(2, 1, 8'h11);
        tick();
        tick();
        tick();
        rst_i = 1'b1;
        rem[3] = 1;
        nxt[3] = 8'h30;
        drive();
        #2;
        chk("s5_rst_wr_en", 32'(fifo_wr_en_o), 32'd0);
        chk("s5_rst_ack", 32'(ack_o), 32'd0);
        tick();
        rst_i = 1'b0;
        #1;
        chk("s5_busy", 32'(busy_o), 32'd0);
        chk("s5_owner", 32'(owner_o), 32'd0);
        expw(5, 1, 8'h12);
        expw(6, 1, 8'h13);
        expw(9, 3, 8'h30);
        repeat (10) tick();

        // rr_ptr=1 with producers 0 and 2 pending.
        do_reset();
        load(0, 1);
        start();
        expw(1, 0, 8'h00);
        repeat (3) tick();
        load(0, 1);
        load(2, 1);
        start();
`ifdef FIFO_ARB_PRIO_EN
        expw(1, 0, 8'h00);
        expw(4, 2, 8'h20);
`else
        expw(1, 2, 8'h20);
        expw(4, 0, 8'h00);
`endif
        tick();
`ifdef FIFO_ARB_PRIO_EN
        chk("s6_owner", 32'(owner_o), 32'd0);
`else
        chk("s6_owner", 32'(owner_o), 32'd2);
`endif
        repeat (8) tick();

        chk("sb_drain", 32'(sbq.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
